// File: rtl/sal_cmd_sched_pkg.sv
// Shared DDR scheduler definitions: command encodings and timer widths.
package sal_cmd_sched_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } sched_cmd_t;

    localparam int unsigned T_WIDTH   = 5;
    localparam int unsigned FAW_WIDTH = 6;
    localparam int unsigned FAW_DEPTH = 4;

endpackage

// File: rtl/sal_cmd_sched_rr_arb.sv
// Round-robin arbiter: search starts at ptr_q, which moves past the winner only when upd_i is set.
module sal_rr_arb #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          upd_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    localparam logic [IW-1:0] ONE = {{(IW-1){1'b0}}, 1'b1};

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;

    // N is a power of two, so IW-bit addition wraps the search naturally.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = ptr_q + IW'(k);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd_i && any_o) begin
            ptr_d = idx_o + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sal_timing_cntr.sv
// Down-counter for inter-command timing; met_o is high once the count has expired.
module sal_timing_cntr #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             met_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // A load wins over the decrement, including the cycle the count hits zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign met_o = (cnt_q == '0);

endmodule

// File: rtl/sal_cmd_sched.sv
// Inter-bank command scheduler: one grant per cycle, CAS > PRE > ACT > REF, RR within a class.
// Optional tFAW window enabled by defining SAL_TFAW_EN. RD is preferred over WR on the same bank.
module sal_cmd_sched
    import sal_cmd_sched_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned BA_WIDTH  = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_BANKS-1:0] act_req_i,
    input  logic [NUM_BANKS-1:0] rd_req_i,
    input  logic [NUM_BANKS-1:0] wr_req_i,
    input  logic [NUM_BANKS-1:0] pre_req_i,
    input  logic [NUM_BANKS-1:0] ref_req_i,
    output logic [NUM_BANKS-1:0] act_gnt_o,
    output logic [NUM_BANKS-1:0] rd_gnt_o,
    output logic [NUM_BANKS-1:0] wr_gnt_o,
    output logic [NUM_BANKS-1:0] pre_gnt_o,
    output logic [NUM_BANKS-1:0] ref_gnt_o,
    input  logic [T_WIDTH-1:0]   t_rrd_m1,
    input  logic [T_WIDTH-1:0]   t_ccd_m1,
    input  logic [T_WIDTH-1:0]   t_wtr_m1,
    input  logic [T_WIDTH-1:0]   t_rtw_m1,
    input  logic [FAW_WIDTH-1:0] t_faw_m1,
    output logic                 cmd_valid_o,
    output sched_cmd_t           cmd_o,
    output logic [BA_WIDTH-1:0]  cmd_ba_o
);

    logic rrd_met, ccd_met, wtr_met, rtw_met, faw_met;
    logic act_ok, rd_ok, wr_ok;
    logic [NUM_BANKS-1:0] rd_elig, wr_elig, cas_req, act_elig;
    logic [NUM_BANKS-1:0] cas_gnt, pre_gnt, act_gnt, ref_gnt;
    logic [BA_WIDTH-1:0]  cas_idx, pre_idx, act_idx, ref_idx;
    logic cas_any, pre_any, act_any, ref_any;
    sched_cmd_t cmd_sel;
    logic [BA_WIDTH-1:0] sel_ba;
    logic act_fire, cas_fire, rd_fire, wr_fire;

    logic                cmd_valid_q, cmd_valid_d;
    sched_cmd_t          cmd_q, cmd_d;
    logic [BA_WIDTH-1:0] cmd_ba_q, cmd_ba_d;

    assign act_ok   = rrd_met && faw_met;
    assign rd_ok    = ccd_met && wtr_met;
    assign wr_ok    = ccd_met && rtw_met;
    assign rd_elig  = rd_req_i & {NUM_BANKS{rd_ok}};
    assign wr_elig  = wr_req_i & {NUM_BANKS{wr_ok}};
    assign cas_req  = rd_elig | wr_elig;
    assign act_elig = act_req_i & {NUM_BANKS{act_ok}};

    assign rd_fire  = (cmd_sel == CMD_RD);
    assign wr_fire  = (cmd_sel == CMD_WR);
    assign cas_fire = rd_fire || wr_fire;
    assign act_fire = (cmd_sel == CMD_ACT);

    sal_rr_arb #(.N(NUM_BANKS), .IW(BA_WIDTH)) u_cas_arb (
        .clk(clk), .rst_n(rst_n), .req_i(cas_req), .upd_i(cas_fire),
        .gnt_o(cas_gnt), .idx_o(cas_idx), .any_o(cas_any));
    sal_rr_arb #(.N(NUM_BANKS), .IW(BA_WIDTH)) u_pre_arb (
        .clk(clk), .rst_n(rst_n), .req_i(pre_req_i), .upd_i(cmd_sel == CMD_PRE),
        .gnt_o(pre_gnt), .idx_o(pre_idx), .any_o(pre_any));
    sal_rr_arb #(.N(NUM_BANKS), .IW(BA_WIDTH)) u_act_arb (
        .clk(clk), .rst_n(rst_n), .req_i(act_elig), .upd_i(act_fire),
        .gnt_o(act_gnt), .idx_o(act_idx), .any_o(act_any));
    sal_rr_arb #(.N(NUM_BANKS), .IW(BA_WIDTH)) u_ref_arb (
        .clk(clk), .rst_n(rst_n), .req_i(ref_req_i), .upd_i(cmd_sel == CMD_REF),
        .gnt_o(ref_gnt), .idx_o(ref_idx), .any_o(ref_any));

    sal_timing_cntr #(.WIDTH(T_WIDTH)) u_rrd (
        .clk(clk), .rst_n(rst_n), .load_i(act_fire), .load_val_i(t_rrd_m1), .met_o(rrd_met));
    sal_timing_cntr #(.WIDTH(T_WIDTH)) u_ccd (
        .clk(clk), .rst_n(rst_n), .load_i(cas_fire), .load_val_i(t_ccd_m1), .met_o(ccd_met));
    sal_timing_cntr #(.WIDTH(T_WIDTH)) u_wtr (
        .clk(clk), .rst_n(rst_n), .load_i(wr_fire), .load_val_i(t_wtr_m1), .met_o(wtr_met));
    sal_timing_cntr #(.WIDTH(T_WIDTH)) u_rtw (
        .clk(clk), .rst_n(rst_n), .load_i(rd_fire), .load_val_i(t_rtw_m1), .met_o(rtw_met));

`ifdef SAL_TFAW_EN
    // One timer per history slot; the slot about to be overwritten holds the oldest of the last four ACTs.
    logic [1:0]           faw_wp_q, faw_wp_d;
    logic [FAW_DEPTH-1:0] faw_slot_met;

    for (genvar g = 0; g < FAW_DEPTH; g++) begin : g_faw
        sal_timing_cntr #(.WIDTH(FAW_WIDTH)) u_faw (
            .clk(clk), .rst_n(rst_n), .load_i(act_fire && (faw_wp_q == 2'(g))),
            .load_val_i(t_faw_m1), .met_o(faw_slot_met[g]));
    end

    always_comb begin
        faw_wp_d = faw_wp_q;
        if (act_fire) begin
            faw_wp_d = faw_wp_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            faw_wp_q <= '0;
        end else begin
            faw_wp_q <= faw_wp_d;
        end
    end

    assign faw_met = faw_slot_met[faw_wp_q];
`else
    logic unused_faw;
    assign unused_faw = ^t_faw_m1;
    assign faw_met    = 1'b1;
`endif

    always_comb begin
        cmd_sel = CMD_NOP;
        sel_ba  = '0;
        if (rst_n) begin
            if (cas_any) begin
                sel_ba  = cas_idx;
                cmd_sel = (|(cas_gnt & rd_elig)) ? CMD_RD : CMD_WR;
            end else if (pre_any) begin
                sel_ba  = pre_idx;
                cmd_sel = CMD_PRE;
            end else if (act_any) begin
                sel_ba  = act_idx;
                cmd_sel = CMD_ACT;
            end else if (ref_any) begin
                sel_ba  = ref_idx;
                cmd_sel = CMD_REF;
            end
        end
    end

    assign rd_gnt_o  = rd_fire  ? cas_gnt : '0;
    assign wr_gnt_o  = wr_fire  ? cas_gnt : '0;
    assign pre_gnt_o = (cmd_sel == CMD_PRE) ? pre_gnt : '0;
    assign act_gnt_o = act_fire ? act_gnt : '0;
    assign ref_gnt_o = (cmd_sel == CMD_REF) ? ref_gnt : '0;

    always_comb begin
        cmd_valid_d = (cmd_sel != CMD_NOP);
        cmd_d       = cmd_sel;
        cmd_ba_d    = sel_ba;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NOP;
            cmd_ba_q    <= '0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            cmd_ba_q    <= cmd_ba_d;
        end
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_o       = cmd_q;
    assign cmd_ba_o    = cmd_ba_q;

endmodule

// File: tb/tb_sal_cmd_sched.sv
// Bench for sal_cmd_sched: cycle-by-cycle reference model plus directed literal checks.
module tb_sal_cmd_sched;
    import sal_cmd_sched_pkg::*;

    localparam int unsigned NB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [NB-1:0] act_req, rd_req, wr_req, pre_req, ref_req;
    logic [NB-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic [4:0] t_rrd, t_ccd, t_wtr, t_rtw;
    logic [5:0] t_faw;
    logic       cmd_valid;
    sched_cmd_t cmd;
    logic [1:0] cmd_ba;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sal_cmd_sched #(.NUM_BANKS(NB), .BA_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
        .pre_req_i(pre_req), .ref_req_i(ref_req),
        .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
        .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
        .t_rrd_m1(t_rrd), .t_ccd_m1(t_ccd), .t_wtr_m1(t_wtr), .t_rtw_m1(t_rtw),
        .t_faw_m1(t_faw),
        .cmd_valid_o(cmd_valid), .cmd_o(cmd), .cmd_ba_o(cmd_ba));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: last-grant timestamps, ACT history, RR start positions.
    longint cyc = 0;
    longint last_act, last_cas, last_rd, last_wr;
    longint hist[$];
    int     ptr[4];
    bit     reg_chk = 0;
    logic       exp_v;
    logic [2:0] exp_cmd;
    logic [1:0] exp_ba;

    function automatic bit rr_pick(input logic [NB-1:0] req, input int p, output int b);
        b = 0;
        for (int k = 0; k < int'(NB); k++) begin
            if (req[(p + k) % NB]) begin
                b = (p + k) % NB;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin : model
        logic [NB-1:0] rd_e, wr_e, act_e;
        logic [NB-1:0] e_act, e_rd, e_wr, e_pre, e_ref;
        logic [5*NB-1:0] all_g, all_r;
        bit ccd_ok, act_ok, faw_ok, legal;
        int b;
        if (reg_chk) begin
            chk("cmd_valid_o", cmd_valid, exp_v);
            chk("cmd_o", cmd, exp_cmd);
            chk("cmd_ba_o", cmd_ba, exp_ba);
        end
        e_act = '0; e_rd = '0; e_wr = '0; e_pre = '0; e_ref = '0;
        exp_v = 1'b0; exp_cmd = CMD_NOP; exp_ba = '0;
        if (!rst_n) begin
            last_act = -1000; last_cas = -1000; last_rd = -1000; last_wr = -1000;
            hist.delete();
            for (int i = 0; i < 4; i++) ptr[i] = 0;
            reg_chk = 1;
        end else begin
            ccd_ok = (cyc - last_cas) > longint'(t_ccd);
            rd_e = rd_req & {NB{ccd_ok && ((cyc - last_wr) > longint'(t_wtr))}};
            wr_e = wr_req & {NB{ccd_ok && ((cyc - last_rd) > longint'(t_rtw))}};
`ifdef SAL_TFAW_EN
            faw_ok = (hist.size() < 4) || ((cyc - hist[0]) > longint'(t_faw));
`else
            faw_ok = 1'b1;
`endif
            act_ok = ((cyc - last_act) > longint'(t_rrd)) && faw_ok;
            act_e = act_req & {NB{act_ok}};
            if (rr_pick(rd_e | wr_e, ptr[0], b)) begin
                if (rd_e[b]) begin e_rd[b] = 1'b1; last_rd = cyc; exp_cmd = CMD_RD; end
                else begin e_wr[b] = 1'b1; last_wr = cyc; exp_cmd = CMD_WR; end
                last_cas = cyc; ptr[0] = (b + 1) % NB;
            end else if (rr_pick(pre_req, ptr[1], b)) begin
                e_pre[b] = 1'b1; ptr[1] = (b + 1) % NB; exp_cmd = CMD_PRE;
            end else if (rr_pick(act_e, ptr[2], b)) begin
                e_act[b] = 1'b1; ptr[2] = (b + 1) % NB; exp_cmd = CMD_ACT;
                last_act = cyc;
                hist.push_back(cyc);
                if (hist.size() > 4) void'(hist.pop_front());
            end else if (rr_pick(ref_req, ptr[3], b)) begin
                e_ref[b] = 1'b1; ptr[3] = (b + 1) % NB; exp_cmd = CMD_REF;
            end
            if (exp_cmd != CMD_NOP) begin
                exp_v = 1'b1; exp_ba = 2'(b);
            end
        end
        chk("act_gnt", act_gnt, e_act);
        chk("rd_gnt", rd_gnt, e_rd);
        chk("wr_gnt", wr_gnt, e_wr);
        chk("pre_gnt", pre_gnt, e_pre);
        chk("ref_gnt", ref_gnt, e_ref);
        all_g = {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt};
        all_r = {act_req, rd_req, wr_req, pre_req, ref_req};
        legal = ($countones(all_g) <= 1) && ((all_g & ~all_r) == '0);
        chk("grant_legal", legal, 1);
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_req();
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
    endtask

    task automatic reset_with(input int rrd, input int ccd, input int wtr, input int rtw, input int faw);
        rst_n = 1'b0;
        clr_req();
        t_rrd = 5'(rrd); t_ccd = 5'(ccd); t_wtr = 5'(wtr); t_rtw = 5'(rtw); t_faw = 6'(faw);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [NB-1:0] rand_vec(input int dens);
        logic [NB-1:0] v;
        for (int i = 0; i < int'(NB); i++) v[i] = ($urandom_range(0, 99) < dens);
        return v;
    endfunction

    logic [NB-1:0] act_seen[13];
    int first_rd, gap_cnt, dens;
    logic [NB-1:0] pre_c2;
    int gc[$];

    initial begin
        rst_n = 1'b0;
        clr_req();
        act_req = '1; rd_req = '1;
        t_rrd = '0; t_ccd = '0; t_wtr = '0; t_rtw = '0; t_faw = '0;
        tick();
        tick();
        chk("reset_grants", {act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt}, 0);
        chk("reset_valid", cmd_valid, 0);
        chk("reset_cmd", cmd, CMD_NOP);
        chk("reset_ba", cmd_ba, 0);

        // CAS beats ACT in the same cycle
        rst_n = 1'b1;
        clr_req();
        rd_req = 4'b0001; act_req = 4'b0010;
        #1;
        chk("prio_rd_gnt", rd_gnt, 4'b0001);
        chk("prio_act_gnt", act_gnt, 0);
        tick();
        clr_req();
        chk("prio_cmd", cmd, CMD_RD);
        chk("prio_ba", cmd_ba, 0);
        chk("prio_valid", cmd_valid, 1);

        // tRRD spacing with all banks requesting ACT
        reset_with(3, 0, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            act_req = '1;
            #1;
            act_seen[i] = act_gnt;
            tick();
        end
        clr_req();
        chk("rrd_c0", act_seen[0], 4'b0001);
        chk("rrd_c4", act_seen[4], 4'b0010);
        chk("rrd_c8", act_seen[8], 4'b0100);
        chk("rrd_c12", act_seen[12], 4'b1000);
        gap_cnt = 0;
        for (int i = 0; i < 13; i++) if ((i % 4) != 0 && act_seen[i] != '0) gap_cnt++;
        chk("rrd_gap", gap_cnt, 0);

        // tWTR: RD after WR waits, PRE slips in meanwhile
        reset_with(0, 0, 5, 0, 0);
        wr_req = 4'b0001;
        #1;
        chk("wtr_wr_c0", wr_gnt, 4'b0001);
        tick();
        wr_req = '0;
        first_rd = -1; pre_c2 = '0;
        for (int c = 1; c <= 20; c++) begin
            rd_req = 4'b0010;
            pre_req = (c == 2) ? 4'b0100 : 4'b0000;
            #1;
            if (c == 2) pre_c2 = pre_gnt;
            if (rd_gnt[1] && first_rd < 0) first_rd = c;
            tick();
        end
        clr_req();
        chk("wtr_first_rd", first_rd, 6);
        chk("wtr_pre_between", pre_c2, 4'b0100);

        // Reset during a pending tCCD countdown
        reset_with(0, 15, 0, 0, 0);
        rd_req = 4'b0001;
        #1;
        chk("ccd_first", rd_gnt, 4'b0001);
        tick();
        rd_req = 4'b0010;
        #1;
        chk("ccd_blocked", rd_gnt, 0);
        tick();
        rst_n = 1'b0;
        clr_req();
        tick();
        rst_n = 1'b1;
        rd_req = 4'b1111;
        #1;
        chk("rst_cas_grant", rd_gnt, 4'b0001);
        tick();
        clr_req();
        chk("rst_cas_cmd", cmd, CMD_RD);

`ifdef SAL_TFAW_EN
        reset_with(0, 0, 0, 0, 19);
        gc.delete();
        for (int c = 0; c < 25; c++) begin
            act_req = '1;
            #1;
            if (act_gnt != '0) gc.push_back(c);
            tick();
        end
        clr_req();
        chk("faw_fourth", (gc.size() >= 4) ? gc[3] : -1, 3);
        chk("faw_fifth", (gc.size() >= 5) ? gc[4] : -1, 20);
`endif

        // Randomized sessions
        for (int s = 0; s < 5; s++) begin
            reset_with($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 6),
                       $urandom_range(0, 6), $urandom_range(0, 24));
            dens = 10 + s * 15;
            for (int c = 0; c < 2000; c++) begin
                act_req = rand_vec(dens);
                rd_req  = rand_vec(dens / 2);
                wr_req  = rand_vec(dens / 2);
                pre_req = rand_vec(dens / 3);
                ref_req = rand_vec(dens / 3);
                rst_n   = ($urandom_range(0, 599) != 0);
                tick();
            end
        end
        rst_n = 1'b1;
        clr_req();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sal_cmd_sched.md
SAL_CMD_SCHED -- requirements
Module: SAL_CMD_SCHED

Interface
REQ-001 Parameter NUM_BANKS, default 4, number of per-bank controllers served (power of 2, 2..16).
REQ-002 Parameter BA_WIDTH, default $clog2(NUM_BANKS), bank-address width.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 act_req_i / rd_req_i / wr_req_i / pre_req_i / ref_req_i  input  NUM_BANKS each  per-bank command requests; bit i = bank i.
REQ-006 act_gnt_o / rd_gnt_o / wr_gnt_o / pre_gnt_o / ref_gnt_o  output  NUM_BANKS each  per-bank grants, combinational, same cycle as request.
REQ-007 t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1  input  5 each  inter-bank timing minus one, static after reset.
REQ-008 t_faw_m1  input  6  four-activate window minus one; used only when SAL_TFAW_EN is defined.
REQ-009 cmd_valid_o  output  1  registered: a command was granted in the previous cycle.
REQ-010 cmd_o  output  3  registered command code of type sched_cmd_t (NOP, ACT, RD, WR, PRE, REF).
REQ-011 cmd_ba_o  output  BA_WIDTH  registered bank of the granted command.

Function
REQ-012 At most one bit across all five grant vectors is asserted per cycle; a grant is asserted only with its matching request bit.
REQ-013 Class priority, highest first: RD/WR (CAS), PRE, ACT, REF; a lower class is granted only when no eligible higher-class request exists.
REQ-014 RD and WR share one CAS class; within a class the bank is chosen round-robin, starting at the bank after the last granted bank of that class.
REQ-015 The round-robin pointer of a class advances only on a grant of that class.
REQ-016 ACT eligible only when tRRD met: at least t_rrd_m1+1 cycles since the previous ACT grant.
REQ-017 RD/WR eligible only when tCCD met since the previous CAS grant.
REQ-018 RD additionally requires tWTR met since the last WR grant; WR additionally requires tRTW met since the last RD grant.
REQ-019 PRE and REF have no inter-bank constraint here; per-bank constraints belong to the bank controller.
REQ-020 An ineligible request gets no grant and does not block lower-priority eligible classes.
REQ-021 Timing value 0 (m1 field = 0) means back-to-back commands of that class are allowed on consecutive cycles.
REQ-022 Each timer is an SAL_TIMING_CNTR instance; load on grant of the constraining command; a load in the same cycle as the count reaching zero takes the load.
REQ-023 cmd_valid_o/cmd_o/cmd_ba_o update one cycle after the grant; NOP with cmd_valid_o=0 when no grant is made.

Reset
REQ-024 While rst_n=0 at posedge, all grants are 0, cmd_valid_o=0, cmd_o=NOP, cmd_ba_o=0, all RR pointers point to bank 0, all timers are zero (met).
REQ-025 Reset asserted mid-operation discards pending timing state; the first cycle after release may grant any class.

Configuration
REQ-026 Macro SAL_TFAW_EN defined: a 4-entry ACT history is kept; ACT is additionally ineligible while 4 ACTs occurred within the last t_faw_m1+1 cycles.
REQ-027 Macro SAL_TFAW_EN undefined: no tFAW logic; t_faw_m1 is ignored and may be tied off.

Structure
REQ-028 sched_cmd_t enum, command encodings, and timer width constants belong in the shared SAL_DDR_PARAMS package/header.
REQ-029 One sub-module SAL_RR_ARB (NUM_BANKS-wide round-robin arbiter with pointer update enable) is instantiated once per class; timers reuse SAL_TIMING_CNTR.

Verification
REQ-030 rd_req_i=4'b0001 and act_req_i=4'b0010 same cycle -> rd_gnt_o=4'b0001, act_gnt_o=0; next cycle cmd_o=RD, cmd_ba_o=0.
REQ-031 t_rrd_m1=3, act_req_i=4'b1111 held -> ACT grants to banks 0,1,2,3 at cycles 0,4,8,12.
REQ-032 t_wtr_m1=5, WR to bank 0 at cycle 0, RD request to bank 1 from cycle 1 -> rd_gnt_o[1] first at cycle 6; PRE to bank 2 granted in between.
REQ-033 SAL_TFAW_EN, t_rrd_m1=0, t_faw_m1=19, four ACTs at cycles 0..3 -> fifth ACT not granted before cycle 20.
REQ-034 rst_n low for one cycle during a pending tCCD countdown -> CAS granted in the first cycle after release, RR pointers at bank 0.
REQ-035 Random request mix, 10k cycles -> never more than one grant per cycle; no grant without request; no starvation beyond NUM_BANKS grants of a class.
